// File: rtl/dac_output_sequencer.sv
// rtl/dac_output_sequencer.sv - mute-windowed mode switch between DDS and direct AXIS sources for the RFDC DAC
module dac_output_sequencer #(
    parameter int AXIS_DATA_WIDTH = 256,
    parameter int MUTE_BEATS      = 16,
    parameter int CNT_WIDTH       = 16
) (
    input  logic                       s_axi_aclk,
    input  logic                       s_axi_aresetn,
    input  logic                       dac_mode_req,
    input  logic [AXIS_DATA_WIDTH-1:0] dds_tdata,
    input  logic                       dds_tvalid,
    input  logic [AXIS_DATA_WIDTH-1:0] direct_tdata,
    input  logic                       direct_tvalid,
    output logic                       direct_tready,
    output logic [AXIS_DATA_WIDTH-1:0] m00_axis_tdata,
    output logic                       m00_axis_tvalid,
    input  logic                       m00_axis_tready,
    output logic                       dac_mode_active,
    output logic                       switch_busy,
    output logic [CNT_WIDTH-1:0]       underrun_count,
    output logic [CNT_WIDTH-1:0]       dds_drop_count
);
    localparam int MCW = $clog2(MUTE_BEATS + 1);
    localparam logic [MCW-1:0] MUTE_INIT = MCW'(MUTE_BEATS);

    typedef enum logic [1:0] {
        ST_MUTE       = 2'd0,
        ST_RUN_DDS    = 2'd1,
        ST_RUN_DIRECT = 2'd2
    } state_t;

    state_t                     state_q, state_d;
    logic [MCW-1:0]             mute_cnt_q, mute_cnt_d;
    logic                       mode_q, mode_d;
    logic                       busy_q, busy_d;
    logic [AXIS_DATA_WIDTH-1:0] tdata_q, tdata_d;
    logic                       tvalid_q;
    logic [CNT_WIDTH-1:0]       underrun_q, drop_q;
    logic                       load, underrun_inc, drop_inc;

    always_comb begin
        load          = !tvalid_q || m00_axis_tready;
        state_d       = state_q;
        mute_cnt_d    = mute_cnt_q;
        mode_d        = mode_q;
        busy_d        = busy_q;
        tdata_d       = tdata_q;
        direct_tready = 1'b0;
        underrun_inc  = 1'b0;
        drop_inc      = 1'b0;
        case (state_q)
            ST_MUTE: begin
                // Each zero beat taken into the output slot uses up one window position;
                // the mode request is only looked at when the last one is taken.
                if (load) begin
                    tdata_d = '0;
                    if (mute_cnt_q <= MCW'(1)) begin
                        mute_cnt_d = '0;
                        mode_d     = dac_mode_req;
                        busy_d     = 1'b0;
                        state_d    = dac_mode_req ? ST_RUN_DIRECT : ST_RUN_DDS;
                    end else begin
                        mute_cnt_d = mute_cnt_q - 1'b1;
                    end
                end
            end
            ST_RUN_DDS: begin
                if (load) tdata_d = dds_tvalid ? dds_tdata : '0;
                drop_inc = dds_tvalid && !load;
            end
            ST_RUN_DIRECT: begin
                direct_tready = load;
                if (load) tdata_d = direct_tvalid ? direct_tdata : '0;
                underrun_inc = load && !direct_tvalid;
            end
            default: state_d = ST_MUTE;
        endcase
        // The beat loaded this cycle still came from the old source above.
        if ((state_q != ST_MUTE) && (dac_mode_req != mode_q)) begin
            state_d    = ST_MUTE;
            mute_cnt_d = MUTE_INIT;
            busy_d     = 1'b1;
        end
    end

    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            state_q    <= ST_MUTE;
            mute_cnt_q <= MUTE_INIT;
            mode_q     <= 1'b0;
            busy_q     <= 1'b1;
            tdata_q    <= '0;
            tvalid_q   <= 1'b0;
            underrun_q <= '0;
            drop_q     <= '0;
        end else begin
            state_q    <= state_d;
            mute_cnt_q <= mute_cnt_d;
            mode_q     <= mode_d;
            busy_q     <= busy_d;
            tdata_q    <= tdata_d;
            tvalid_q   <= 1'b1;
            if (underrun_inc && (underrun_q != '1)) underrun_q <= underrun_q + 1'b1;
            if (drop_inc && (drop_q != '1)) drop_q <= drop_q + 1'b1;
        end
    end

    assign m00_axis_tdata  = tdata_q;
    assign m00_axis_tvalid = tvalid_q;
    assign dac_mode_active = mode_q;
    assign switch_busy     = busy_q;
    assign underrun_count  = underrun_q;
    assign dds_drop_count  = drop_q;

endmodule

// File: tb/tb_dac_output_sequencer.sv
// tb/tb_dac_output_sequencer.sv - vector table, hand sequences and random run against a beat-level model
module tb_dac_output_sequencer;
    localparam int W    = 256;
    localparam int MB   = 16;
    localparam int CW   = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          dac_mode_req = 1'b0;
    logic [W-1:0]  dds_tdata = '0;
    logic          dds_tvalid = 1'b0;
    logic [W-1:0]  direct_tdata = '0;
    logic          direct_tvalid = 1'b0;
    logic          direct_tready;
    logic [W-1:0]  m00_axis_tdata;
    logic          m00_axis_tvalid;
    logic          m00_axis_tready = 1'b0;
    logic          dac_mode_active;
    logic          switch_busy;
    logic [CW-1:0] underrun_count;
    logic [CW-1:0] dds_drop_count;

    dac_output_sequencer #(.AXIS_DATA_WIDTH(W), .MUTE_BEATS(MB), .CNT_WIDTH(CW)) dut (
        .s_axi_aclk(clk), .s_axi_aresetn(rst_n), .dac_mode_req(dac_mode_req),
        .dds_tdata(dds_tdata), .dds_tvalid(dds_tvalid),
        .direct_tdata(direct_tdata), .direct_tvalid(direct_tvalid), .direct_tready(direct_tready),
        .m00_axis_tdata(m00_axis_tdata), .m00_axis_tvalid(m00_axis_tvalid), .m00_axis_tready(m00_axis_tready),
        .dac_mode_active(dac_mode_active), .switch_busy(switch_busy),
        .underrun_count(underrun_count), .dds_drop_count(dds_drop_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    logic [31:0] ramp = 32'd1;

    // Beat-level model: output slot contents, mode, remaining zero beats of a window, event tallies.
    logic [W-1:0] m_data;
    bit           m_valid, m_mode, m_muting;
    int           m_mute_left, m_und, m_drop;

    task automatic model_reset();
        m_data = '0; m_valid = 0; m_mode = 0; m_muting = 1;
        m_mute_left = MB; m_und = 0; m_drop = 0;
    endtask

    function automatic bit model_ready();
        return !m_muting && m_mode && (!m_valid || m00_axis_tready);
    endfunction

    task automatic model_step();
        bit slot_free;
        slot_free = !m_valid || m00_axis_tready;
        if (m_muting) begin
            if (slot_free) begin
                m_data = '0;
                m_mute_left--;
                if (m_mute_left == 0) begin
                    m_muting = 0;
                    m_mode   = dac_mode_req;
                end
            end
        end else begin
            if (m_mode == 0) begin
                if (slot_free) m_data = dds_tvalid ? dds_tdata : '0;
                if (dds_tvalid && !slot_free && m_drop < CMAX) m_drop++;
            end else begin
                if (slot_free) m_data = direct_tvalid ? direct_tdata : '0;
                if (slot_free && !direct_tvalid && m_und < CMAX) m_und++;
            end
            if (dac_mode_req != m_mode) begin
                m_muting    = 1;
                m_mute_left = MB;
            end
        end
        m_valid = 1;
    endtask

    task automatic chk(input string name, input logic [299:0] act, input logic [299:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [W-1:0] rand_w();
        logic [W-1:0] v;
        for (int k = 0; k < W / 32; k++) v[k*32 +: 32] = $urandom;
        return v;
    endfunction

    // Drive at the falling edge, check ready combinationally, step the model at the rising edge,
    // then compare registered outputs at the next falling edge.
    task automatic cycle(input logic req, input logic tr, input logic dv, input logic xv);
        dac_mode_req    = req;
        m00_axis_tready = tr;
        dds_tvalid      = dv;
        direct_tvalid   = xv;
        dds_tdata       = {8{ramp}};
        ramp            = ramp + 1;
        direct_tdata    = rand_w();
        #1;
        chk("direct_tready", 300'(direct_tready), 300'(model_ready()));
        @(posedge clk);
        model_step();
        @(negedge clk);
        chk("tdata", 300'(m00_axis_tdata), 300'(m_data));
        chk("status", 300'({m00_axis_tvalid, dac_mode_active, switch_busy, underrun_count, dds_drop_count}),
            300'({m_valid, m_mode, m_muting, CW'(m_und), CW'(m_drop)}));
    endtask

    typedef struct {
        logic req, tr, dv, xv;
        int   n;
        logic busy, mode;
        int   und, drop;
    } vec_t;
    vec_t vecs[$];

    task automatic run_vec(input int i);
        for (int c = 0; c < vecs[i].n; c++) cycle(vecs[i].req, vecs[i].tr, vecs[i].dv, vecs[i].xv);
        chk($sformatf("vec%0d", i), 300'({switch_busy, dac_mode_active, underrun_count, dds_drop_count}),
            300'({vecs[i].busy, vecs[i].mode, CW'(vecs[i].und), CW'(vecs[i].drop)}));
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_tvalid"}, 300'(m00_axis_tvalid), 300'(0));
        chk({tag, "_tdata"}, 300'(m00_axis_tdata), 300'(0));
        chk({tag, "_ready"}, 300'(direct_tready), 300'(0));
        chk({tag, "_mode_busy"}, 300'({dac_mode_active, switch_busy}), 300'(2'b01));
        chk({tag, "_counters"}, 300'({underrun_count, dds_drop_count}), 300'(0));
    endtask

    initial begin
        //                 req tr dv xv  n  busy mode und drop
        vecs.push_back('{1'b0, 1'b1, 1'b1, 1'b0, 15, 1'b1, 1'b0,  0,  0}); // 15 of 16 zero beats
        vecs.push_back('{1'b0, 1'b1, 1'b1, 1'b0,  1, 1'b0, 1'b0,  0,  0}); // 16th zero ends window
        vecs.push_back('{1'b0, 1'b1, 1'b1, 1'b0,  8, 1'b0, 1'b0,  0,  0}); // DDS ramp flowing
        vecs.push_back('{1'b0, 1'b0, 1'b1, 1'b0, 10, 1'b0, 1'b0,  0, 10}); // stall: 10 drops
        vecs.push_back('{1'b1, 1'b1, 1'b1, 1'b1,  1, 1'b1, 1'b0,  0, 10}); // switch detected
        vecs.push_back('{1'b1, 1'b1, 1'b1, 1'b1, 15, 1'b1, 1'b0,  0, 10});
        vecs.push_back('{1'b1, 1'b1, 1'b1, 1'b1,  1, 1'b0, 1'b1,  0, 10}); // now direct
        vecs.push_back('{1'b1, 1'b1, 1'b0, 1'b1,  6, 1'b0, 1'b1,  0, 10});
        vecs.push_back('{1'b1, 1'b1, 1'b1, 1'b0,  5, 1'b0, 1'b1,  5, 10}); // 5 underruns
        vecs.push_back('{1'b1, 1'b0, 1'b1, 1'b1,  3, 1'b0, 1'b1,  5, 10}); // direct stall
        vecs.push_back('{1'b0, 1'b1, 1'b1, 1'b1,  1, 1'b1, 1'b1,  5, 10}); // switch with handshake
        vecs.push_back('{1'b0, 1'b1, 1'b1, 1'b1,  4, 1'b1, 1'b1,  5, 10}); // req toggles in window
        vecs.push_back('{1'b1, 1'b1, 1'b1, 1'b1,  2, 1'b1, 1'b1,  5, 10});
        vecs.push_back('{1'b0, 1'b1, 1'b1, 1'b1,  2, 1'b1, 1'b1,  5, 10});
        vecs.push_back('{1'b1, 1'b0, 1'b1, 1'b1,  5, 1'b1, 1'b1,  5, 10}); // stall inside window
        vecs.push_back('{1'b1, 1'b1, 1'b1, 1'b1,  7, 1'b1, 1'b1,  5, 10});
        vecs.push_back('{1'b1, 1'b1, 1'b1, 1'b1,  1, 1'b0, 1'b1,  5, 10}); // exits to direct
        vecs.push_back('{1'b1, 1'b1, 1'b1, 1'b0, 12, 1'b0, 1'b1, 15, 10}); // underrun saturates
        vecs.push_back('{1'b0, 1'b1, 1'b1, 1'b1,  1, 1'b1, 1'b1, 15, 10});
        vecs.push_back('{1'b0, 1'b1, 1'b1, 1'b1, 16, 1'b0, 1'b0, 15, 10});
        vecs.push_back('{1'b0, 1'b0, 1'b1, 1'b0,  7, 1'b0, 1'b0, 15, 15}); // drops saturate

        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_reset_values("reset");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) run_vec(i);

        begin
            logic req;
            req = dac_mode_req;
            for (int c = 0; c < 1500; c++) begin
                if ($urandom_range(0, 49) == 0) req = ~req;
                cycle(req, $urandom_range(0, 3) != 0, $urandom_range(0, 4) != 0, $urandom_range(0, 3) != 0);
            end
        end

        for (int c = 0; c < 40; c++) cycle(1'b1, 1'b1, 1'b1, 1'b1);
        chk("pre_reset_direct", 300'({dac_mode_active, switch_busy}), 300'(2'b10));
        direct_tvalid = 1'b1;
        direct_tdata  = rand_w();
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_reset_values("midreset");
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) run_vec(i);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
